// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Pipeline sequencer for the 5-stage RV32I core. It covers the
//               hazards that E-stage forwarding cannot resolve:
//               - load-use: stall F/D and bubble E
//               - taken branch/jump: flush D/E
//               - multi-cycle data-memory access: freeze F..M and bubble W,
//                 with a timeout that abandons the access
//               It also keeps stall/flush cycle counters.
// Ports       : clk, rst (async, active-high)
//               Rs1_D/Rs2_D/RD_E/RegWriteE/ResultSrcE - load-use detection
//               PCSrcE                               - taken branch in E
//               MemReqM/MemReadyM                    - data-memory handshake
//               CntClr                               - clear perf counters
//               Stall*/Flush*                        - pipeline control
//               MemErr                               - timeout pulse
//               StallCnt/FlushCnt                    - perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic [4:0]       RD_E,
   input  logic             RegWriteE,
   input  logic             ResultSrcE,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   input  logic             CntClr,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam int WC_W = $clog2(TIMEOUT + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic              mem_err_q, mem_err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              mem_stall;
   logic              load_use;

   // Memory-wait FSM. The first cycle of an unready access stalls from IDLE,
   // so a timeout after TIMEOUT counts gives TIMEOUT stalled cycles in total.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = 1'b0;
      mem_stall  = 1'b0;
      case (state_q)
         IDLE: begin
            if (MemReqM && !MemReadyM) begin
               mem_stall  = 1'b1;
               state_d    = WAIT;
               wait_cnt_d = WC_W'(1);
            end
         end
         WAIT: begin
            // MemReqM is deliberately ignored here: only ready or timeout exits.
            if (MemReadyM) begin
               state_d    = IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WC_W'(TIMEOUT)) begin
               mem_err_d  = 1'b1;
               state_d    = IDLE;
               wait_cnt_d = '0;
            end else begin
               mem_stall  = 1'b1;
               wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   // x0 is hardwired zero, so a load targeting it can never create a hazard.
   assign load_use = ResultSrcE && RegWriteE && (RD_E != 5'd0) &&
                     ((RD_E == Rs1_D) || (RD_E == Rs2_D));

   // Prioritised pipeline control. A memory freeze holds E, so a branch or
   // load-use sitting there is simply re-evaluated once the freeze lifts.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (!rst) begin
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   // Clear takes precedence over a same-cycle increment; wrap is natural.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (CntClr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (StallF) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (FlushE) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign MemErr   = mem_err_q;
   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_controller
// Description : Directed self-checking bench for hazard_controller
//               (TIMEOUT=4, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] Rs1_D, Rs2_D, RD_E;
   logic       RegWriteE, ResultSrcE, PCSrcE, MemReqM, MemReadyM, CntClr;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [3:0] StallCnt, FlushCnt;

   int total = 0;
   int bad   = 0;

   // Output vector order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
   localparam logic [6:0] P_NONE = 7'b0000000;
   localparam logic [6:0] P_MEM  = 7'b1111001;
   localparam logic [6:0] P_BR   = 7'b0000110;
   localparam logic [6:0] P_LU   = 7'b1100010;

   always #5 clk = ~clk;

   hazard_controller #(.TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CntClr(CntClr),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [6:0] exp);
      chk(tag, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, exp});
   endtask

   task automatic chk_cnt(input string tag, input logic [3:0] s, input logic [3:0] f);
      chk({tag, "_stallcnt"}, {28'd0, StallCnt}, {28'd0, s});
      chk({tag, "_flushcnt"}, {28'd0, FlushCnt}, {28'd0, f});
   endtask

   task automatic idle_in();
      Rs1_D = 5'd0; Rs2_D = 5'd0; RD_E = 5'd0;
      RegWriteE = 1'b0; ResultSrcE = 1'b0; PCSrcE = 1'b0;
      MemReqM = 1'b0; MemReadyM = 1'b0; CntClr = 1'b0;
   endtask

   task automatic set_lu();
      RD_E = 5'd5; ResultSrcE = 1'b1; RegWriteE = 1'b1; Rs1_D = 5'd1; Rs2_D = 5'd5;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_in();
      rst = 1'b1;
      set_lu();
      #2;
      chk_out("reset_outs", P_NONE);
      chk("reset_memerr", {31'd0, MemErr}, 32'd0);
      chk_cnt("reset", 4'd0, 4'd0);
      idle_in();
      tick();
      rst = 1'b0;

      // T1 load-use
      set_lu();
      #1 chk_out("t1_loaduse", P_LU);
      tick();
      idle_in();
      #1 chk_out("t1_after", P_NONE);
      chk_cnt("t1", 4'd1, 4'd1);

      // T2 x0 never hazards, then branch overrides load-use
      RD_E = 5'd0; ResultSrcE = 1'b1; RegWriteE = 1'b1; Rs1_D = 5'd0;
      #1 chk_out("t2_x0", P_NONE);
      tick();
      chk_cnt("t2_x0", 4'd1, 4'd1);
      set_lu(); PCSrcE = 1'b1;
      #1 chk_out("t2_branch", P_BR);
      tick();
      idle_in();
      #1 chk_cnt("t2_branch", 4'd1, 4'd2);

      // T3 three-cycle memory wait; branch in E must be deferred
      MemReqM = 1'b1; MemReadyM = 1'b0;
      for (int i = 0; i < 3; i++) begin
         PCSrcE = (i == 1);
         #1 chk_out($sformatf("t3_wait%0d", i), P_MEM);
         tick();
      end
      PCSrcE = 1'b0; MemReadyM = 1'b1;
      #1 chk_out("t3_ready", P_NONE);
      tick();
      idle_in();
      #1 chk_cnt("t3", 4'd4, 4'd2);

      // T4 timeout after 4 stalled cycles, MemErr one cycle later
      MemReqM = 1'b1; MemReadyM = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1 chk_out($sformatf("t4_wait%0d", i), P_MEM);
         tick();
      end
      #1 chk_out("t4_timeout", P_NONE);
      chk("t4_memerr_early", {31'd0, MemErr}, 32'd0);
      tick();
      MemReqM = 1'b0;
      #1 chk("t4_memerr", {31'd0, MemErr}, 32'd1);
      chk_out("t4_idle", P_NONE);
      tick();
      chk("t4_memerr_once", {31'd0, MemErr}, 32'd0);
      chk_cnt("t4", 4'd8, 4'd2);

      // T5 counter clear, wrap, and clear beating increment
      CntClr = 1'b1;
      tick();
      CntClr = 1'b0;
      chk_cnt("t5_clr", 4'd0, 4'd0);
      set_lu();
      for (int i = 0; i < 17; i++) tick();
      chk_cnt("t5_wrap", 4'd1, 4'd1);
      CntClr = 1'b1;
      #1 chk_out("t5_clr_stall", P_LU);
      tick();
      chk_cnt("t5_clr_wins", 4'd0, 4'd0);
      idle_in();

      // T6 reset in the second WAIT cycle
      MemReqM = 1'b1; MemReadyM = 1'b0;
      tick();
      tick();
      #1 chk_out("t6_prereset", P_MEM);
      rst = 1'b1;
      #1 chk_out("t6_rst", P_NONE);
      chk_cnt("t6_rst", 4'd0, 4'd0);
      tick();
      tick();
      MemReqM = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("t6_nomemerr%0d", i), {31'd0, MemErr}, 32'd0);
      end
      // Back in IDLE: a ready access does not stall, an unready one stalls once.
      MemReqM = 1'b1; MemReadyM = 1'b1;
      #1 chk_out("t6_idle_ready", P_NONE);
      MemReadyM = 1'b0;
      #1 chk_out("t6_idle_req", P_MEM);
      tick();
      idle_in();
      MemReadyM = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
